// File: rtl/hdc_mapper_pkg.sv
// Shared types and width helpers for the HDC sliding-window mapper.
package hdc_mapper_pkg;

   typedef enum logic [1:0] {
      MODE_PASS      = 2'd0,
      MODE_NGRAM     = 2'd1,
      MODE_SIGNATURE = 2'd2
   } mode_e;

   typedef enum logic {
      ST_ACCEPT = 1'b0,
      ST_EMIT   = 1'b1
   } state_e;

   // Width able to hold a window depth of 0..max_window.
   function automatic int unsigned win_w(input int unsigned max_window);
      return $clog2(max_window + 1);
   endfunction

   // Width able to index positions 0..max_window-1.
   function automatic int unsigned idx_w(input int unsigned max_window);
      return (max_window > 1) ? $clog2(max_window) : 1;
   endfunction

   // Reserved encoding 3 falls back to PASS.
   function automatic mode_e decode_mode(input logic [1:0] raw);
      case (raw)
         2'd1:    return MODE_NGRAM;
         2'd2:    return MODE_SIGNATURE;
         default: return MODE_PASS;
      endcase
   endfunction

endpackage

// File: rtl/window_xor_reduce.sv
// XOR of the active window entries (index < win_i), excluding position k_i.
module window_xor_reduce
   import hdc_mapper_pkg::*;
#(
   parameter int unsigned VALUE_W    = 6,
   parameter int unsigned MAX_WINDOW = 12
) (
   input  logic [MAX_WINDOW*VALUE_W-1:0]   queue_i,
   input  logic [win_w(MAX_WINDOW)-1:0]    win_i,
   input  logic [idx_w(MAX_WINDOW)-1:0]    k_i,
   output logic [VALUE_W-1:0]              xor_o
);

   localparam int unsigned WIN_W = win_w(MAX_WINDOW);
   localparam int unsigned IDX_W = idx_w(MAX_WINDOW);

   always_comb begin
      xor_o = '0;
      for (int unsigned j = 0; j < MAX_WINDOW; j++) begin
         if ((WIN_W'(j) < win_i) && (IDX_W'(j) != k_i)) begin
            xor_o = xor_o ^ queue_i[j*VALUE_W +: VALUE_W];
         end
      end
   end

endmodule

// File: rtl/window_mapper_v2.sv
// Sliding-window input mapper: buffers the last symbols and emits one window
// element per cycle with item-memory index, permutation shift and flags.
module window_mapper_v2
   import hdc_mapper_pkg::*;
#(
   parameter int unsigned VALUE_W    = 6,
   parameter int unsigned MAX_WINDOW = 12,
   parameter int unsigned SHIFT_W    = 11,
   parameter int unsigned STRIDE_W   = 4
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          clear_i,
   input  logic [1:0]                    mode_i,
   input  logic [win_w(MAX_WINDOW)-1:0]  window_size_i,
   input  logic [STRIDE_W-1:0]           stride_i,
   input  logic [SHIFT_W-1:0]            shift_in_i,
   input  logic                          in_valid_i,
   output logic                          in_ready_o,
   input  logic [VALUE_W-1:0]            in_value_i,
   output logic                          out_valid_o,
   input  logic                          out_ready_i,
   output logic [VALUE_W-1:0]            out_value_o,
   output logic [SHIFT_W-1:0]            out_shift_o,
   output logic                          out_zero_o,
   output logic                          out_last_o,
   output logic                          busy_o
);

   localparam int unsigned WIN_W = win_w(MAX_WINDOW);
   localparam int unsigned IDX_W = idx_w(MAX_WINDOW);

   state_e                            state_q, state_d;
   logic [MAX_WINDOW-1:0][VALUE_W-1:0] queue_q, queue_d;
   logic [WIN_W-1:0]                  fill_q, fill_d;
   logic [IDX_W-1:0]                  k_q, k_d;
   logic [STRIDE_W-1:0]               cnt_q, cnt_d;

   mode_e                             mode_q, mode_live, mode_eff;
   logic [WIN_W-1:0]                  win_q, win_live, win_eff;
   logic [STRIDE_W-1:0]               stride_q, stride_live, stride_eff;

   logic                              flush;
   logic                              capture;
   logic                              at_last;
   logic [VALUE_W-1:0]                xor_val;

   assign flush   = rst_i | clear_i;
   assign capture = (state_q == ST_ACCEPT) && (fill_q == '0);

   always_comb begin
      mode_live = decode_mode(mode_i);
      if (window_size_i == '0) begin
         win_live = WIN_W'(1);
      end else if (window_size_i > WIN_W'(MAX_WINDOW)) begin
         win_live = WIN_W'(MAX_WINDOW);
      end else begin
         win_live = window_size_i;
      end
      stride_live = (stride_i == '0) ? STRIDE_W'(1) : stride_i;
   end

   // While capture is open the live config is used directly, so the first
   // symbol after a clear already sees the new mode/W/stride.
   assign mode_eff   = capture ? mode_live   : mode_q;
   assign win_eff    = capture ? win_live    : win_q;
   assign stride_eff = capture ? stride_live : stride_q;

   window_xor_reduce #(
      .VALUE_W   (VALUE_W),
      .MAX_WINDOW(MAX_WINDOW)
   ) u_xor (
      .queue_i(queue_q),
      .win_i  (win_q),
      .k_i    (k_q),
      .xor_o  (xor_val)
   );

   always_ff @(posedge clk_i) begin
      if (flush) begin
         state_q  <= ST_ACCEPT;
         queue_q  <= '0;
         fill_q   <= '0;
         k_q      <= '0;
         cnt_q    <= '0;
         mode_q   <= MODE_PASS;
         win_q    <= WIN_W'(1);
         stride_q <= STRIDE_W'(1);
      end else begin
         state_q <= state_d;
         queue_q <= queue_d;
         fill_q  <= fill_d;
         k_q     <= k_d;
         cnt_q   <= cnt_d;
         if (capture) begin
            mode_q   <= mode_live;
            win_q    <= win_live;
            stride_q <= stride_live;
         end
      end
   end

   assign at_last = (WIN_W'(k_q) == (win_q - WIN_W'(1)));

   always_comb begin
      state_d     = state_q;
      queue_d     = queue_q;
      fill_d      = fill_q;
      k_d         = k_q;
      cnt_d       = cnt_q;
      in_ready_o  = 1'b0;
      out_valid_o = 1'b0;
      out_value_o = '0;
      out_shift_o = '0;
      out_zero_o  = 1'b0;
      out_last_o  = 1'b0;
      busy_o      = (state_q == ST_EMIT);

      if (mode_eff == MODE_PASS) begin
         in_ready_o  = out_ready_i & ~flush;
         out_valid_o = in_valid_i & ~flush;
         out_value_o = in_value_i;
         out_shift_o = shift_in_i;
         out_last_o  = 1'b1;
      end else begin
         unique case (state_q)
            ST_ACCEPT: begin
               in_ready_o = ~flush;
               if (in_valid_i) begin
                  queue_d[0] = in_value_i;
                  for (int unsigned i = 1; i < MAX_WINDOW; i++) begin
                     queue_d[i] = queue_q[i-1];
                  end
                  fill_d = (fill_q < win_eff) ? (fill_q + WIN_W'(1)) : win_eff;
                  if (cnt_q == (stride_eff - STRIDE_W'(1))) begin
                     cnt_d   = '0;
                     k_d     = '0;
                     state_d = ST_EMIT;
                  end else begin
                     cnt_d = cnt_q + STRIDE_W'(1);
                  end
               end
            end
            ST_EMIT: begin
               out_valid_o = 1'b1;
               out_value_o = queue_q[k_q];
               out_zero_o  = (WIN_W'(k_q) >= fill_q);
               out_last_o  = at_last;
               if (mode_q == MODE_SIGNATURE) begin
                  out_shift_o = SHIFT_W'(k_q) + SHIFT_W'(xor_val);
               end else begin
                  out_shift_o = SHIFT_W'(k_q);
               end
               if (out_ready_i) begin
                  if (at_last) begin
                     state_d = ST_ACCEPT;
                  end else begin
                     k_d = k_q + IDX_W'(1);
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_window_mapper_v2.sv
// Randomized self-checking bench for window_mapper_v2 against a window-level model.
module tb_window_mapper_v2;

   logic        clk;
   logic        rst;
   logic        clear;
   logic [1:0]  mode;
   logic [3:0]  wsize;
   logic [3:0]  stride;
   logic [10:0] shift_in;
   logic        in_valid;
   logic        in_ready;
   logic [5:0]  in_value;
   logic        out_valid;
   logic        out_ready;
   logic [5:0]  out_value;
   logic [10:0] out_shift;
   logic        out_zero;
   logic        out_last;
   logic        busy;

   int pass_cnt = 0;
   int total_cnt = 0;

   int          hist[$];
   logic [18:0] rec[16];
   logic [18:0] exp_e[16];
   int          exp_n;

   window_mapper_v2 #(
      .VALUE_W   (6),
      .MAX_WINDOW(12),
      .SHIFT_W   (11),
      .STRIDE_W  (4)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .clear_i      (clear),
      .mode_i       (mode),
      .window_size_i(wsize),
      .stride_i     (stride),
      .shift_in_i   (shift_in),
      .in_valid_i   (in_valid),
      .in_ready_o   (in_ready),
      .in_value_i   (in_value),
      .out_valid_o  (out_valid),
      .out_ready_i  (out_ready),
      .out_value_o  (out_value),
      .out_shift_o  (out_shift),
      .out_zero_o   (out_zero),
      .out_last_o   (out_last),
      .busy_o       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected window built from the symbol history (newest first) since the last clear.
   function automatic void model_window(input int w, input bit sig);
      int q[12];
      int f;
      f = (hist.size() < w) ? hist.size() : w;
      for (int j = 0; j < 12; j++) q[j] = (j < w && j < hist.size()) ? hist[j] : 0;
      exp_n = w;
      for (int k = 0; k < w; k++) begin
         int x;
         int sh;
         logic z;
         logic l;
         x = 0;
         for (int j = 0; j < w; j++) if (j != k) x = x ^ q[j];
         sh = sig ? ((k + x) % 2048) : k;
         z  = (k >= f);
         l  = (k == w - 1);
         exp_e[k] = {6'(q[k]), 11'(sh), z, l};
      end
   endfunction

   function automatic int clamp_w(input int w);
      return (w == 0) ? 1 : ((w > 12) ? 12 : w);
   endfunction

   task automatic pulse_clear();
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      hist.delete();
   endtask

   task automatic send_sym(input int v);
      in_valid = 1'b1;
      in_value = 6'(v);
      @(negedge clk);
      in_valid = 1'b0;
      hist.push_front(v & 63);
   endtask

   task automatic collect(input bit rnd, output int n, output bit to);
      n  = 0;
      to = 1'b1;
      for (int c = 0; c < 100; c++) begin
         out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         if (out_valid && out_ready) begin
            if (n < 16) rec[n] = {out_value, out_shift, out_zero, out_last};
            n++;
            if (out_last) begin
               to = 1'b0;
               @(negedge clk);
               break;
            end
         end
         @(negedge clk);
      end
      out_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1; clear = 1'b0; mode = 2'd2; wsize = 4'd3; stride = 4'd1;
      shift_in = '0; in_valid = 1'b0; in_value = '0; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      total_cnt++;
      if (in_ready !== 1'b0) $display("FAIL reset_in_ready got=%b exp=0", in_ready); else pass_cnt++;
      @(negedge clk);
      rst = 1'b0;
      hist.delete();
      #1;
      total_cnt++;
      if ({out_valid, out_last, out_zero, busy, in_ready} !== 5'b00001)
         $display("FAIL reset_state got v/l/z/b/r=%b exp=00001", {out_valid, out_last, out_zero, busy, in_ready});
      else pass_cnt++;
      @(negedge clk);
   endtask

   task automatic test_signature();
      int n; bit to;
      int syms[3] = '{5, 3, 6};
      mode = 2'd2; wsize = 4'd3; stride = 4'd1;
      pulse_clear();
      for (int i = 0; i < 3; i++) begin
         send_sym(syms[i]);
         #1;
         total_cnt++;
         if ({out_valid, busy} !== 2'b11) $display("FAIL sig_latency win=%0d got v/b=%b exp=11", i, {out_valid, busy});
         else pass_cnt++;
         model_window(3, 1'b1);
         collect(1'b0, n, to);
         total_cnt++;
         if (to || n != exp_n) $display("FAIL sig_len win=%0d got=%0d to=%0b exp=%0d", i, n, to, exp_n); else pass_cnt++;
         for (int k = 0; k < exp_n && k < n; k++) begin
            total_cnt++;
            if (rec[k] !== exp_e[k]) $display("FAIL sig_elem win=%0d k=%0d got=%h exp=%h", i, k, rec[k], exp_e[k]);
            else pass_cnt++;
         end
      end
   endtask

   task automatic test_ngram_stride();
      int n; bit to;
      mode = 2'd1; wsize = 4'd4; stride = 4'd2;
      pulse_clear();
      for (int i = 1; i <= 4; i++) begin
         send_sym(i);
         #1;
         if (i % 2 == 1) begin
            total_cnt++;
            if ({out_valid, in_ready} !== 2'b01) $display("FAIL ngram_no_emit in=%0d got v/r=%b exp=01", i, {out_valid, in_ready});
            else pass_cnt++;
         end else begin
            model_window(4, 1'b0);
            collect(1'b0, n, to);
            total_cnt++;
            if (to || n != exp_n) $display("FAIL ngram_len in=%0d got=%0d exp=%0d", i, n, exp_n); else pass_cnt++;
            for (int k = 0; k < exp_n && k < n; k++) begin
               total_cnt++;
               if (rec[k] !== exp_e[k]) $display("FAIL ngram_elem in=%0d k=%0d got=%h exp=%h", i, k, rec[k], exp_e[k]);
               else pass_cnt++;
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int n; bit to;
      mode = 2'd2; wsize = 4'd3; stride = 4'd1;
      pulse_clear();
      send_sym(7);  collect(1'b0, n, to);
      send_sym(9);  collect(1'b0, n, to);
      send_sym(11);
      model_window(3, 1'b1);
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_value  = 6'd33;
      for (int c = 0; c < 5; c++) begin
         #1;
         total_cnt++;
         if ({out_valid, in_ready, busy, out_value, out_shift, out_zero, out_last} !== {3'b101, exp_e[1]})
            $display("FAIL stall_hold c=%0d got v/r/b=%b elem=%h exp 101 %h", c,
                     {out_valid, in_ready, busy}, {out_value, out_shift, out_zero, out_last}, exp_e[1]);
         else pass_cnt++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      collect(1'b0, n, to);
      total_cnt++;
      if (to || n != 2) $display("FAIL stall_rest_len got=%0d exp=2", n); else pass_cnt++;
      for (int k = 0; k < 2 && k < n; k++) begin
         total_cnt++;
         if (rec[k] !== exp_e[k+1]) $display("FAIL stall_rest k=%0d got=%h exp=%h", k + 1, rec[k], exp_e[k+1]);
         else pass_cnt++;
      end
      // the stalled 33 must not have entered the queue
      send_sym(13);
      model_window(3, 1'b1);
      collect(1'b0, n, to);
      total_cnt++;
      if (to || n != 3 || rec[0] !== exp_e[0] || rec[1] !== exp_e[1] || rec[2] !== exp_e[2])
         $display("FAIL stall_after got=%h %h %h exp=%h %h %h", rec[0], rec[1], rec[2], exp_e[0], exp_e[1], exp_e[2]);
      else pass_cnt++;
   endtask

   task automatic test_clear_abort();
      int n; bit to;
      mode = 2'd1; wsize = 4'd4; stride = 4'd1;
      pulse_clear();
      send_sym(21); collect(1'b0, n, to);
      send_sym(22); collect(1'b0, n, to);
      send_sym(23);
      @(negedge clk);
      clear    = 1'b1;
      in_valid = 1'b1;
      in_value = 6'd44;
      #1;
      total_cnt++;
      if (in_ready !== 1'b0) $display("FAIL clear_in_ready got=%b exp=0", in_ready); else pass_cnt++;
      @(negedge clk);
      clear = 1'b0;
      in_valid = 1'b0;
      hist.delete();
      #1;
      total_cnt++;
      if ({out_valid, busy, out_last, out_zero, in_ready} !== 5'b00001)
         $display("FAIL clear_state got v/b/l/z/r=%b exp=00001", {out_valid, busy, out_last, out_zero, in_ready});
      else pass_cnt++;
      send_sym(25);
      model_window(4, 1'b0);
      collect(1'b0, n, to);
      total_cnt++;
      if (to || n != 4) $display("FAIL clear_len got=%0d exp=4", n); else pass_cnt++;
      for (int k = 0; k < 4 && k < n; k++) begin
         total_cnt++;
         if (rec[k] !== exp_e[k]) $display("FAIL clear_elem k=%0d got=%h exp=%h", k, rec[k], exp_e[k]);
         else pass_cnt++;
      end
   endtask

   task automatic test_config_latch();
      int n; bit to;
      mode = 2'd2; wsize = 4'd3; stride = 4'd1;
      pulse_clear();
      send_sym(40); collect(1'b0, n, to);
      wsize = 4'd5;
      send_sym(41);
      model_window(3, 1'b1);
      collect(1'b0, n, to);
      total_cnt++;
      if (to || n != 3 || rec[2] !== exp_e[2]) $display("FAIL latch_ignored got n=%0d last=%h exp n=3 last=%h", n, rec[2], exp_e[2]);
      else pass_cnt++;
      pulse_clear();
      send_sym(42);
      model_window(5, 1'b1);
      collect(1'b0, n, to);
      total_cnt++;
      if (to || n != 5) $display("FAIL latch_applied got n=%0d exp=5", n); else pass_cnt++;
      for (int k = 0; k < 5 && k < n; k++) begin
         total_cnt++;
         if (rec[k] !== exp_e[k]) $display("FAIL latch_elem k=%0d got=%h exp=%h", k, rec[k], exp_e[k]);
         else pass_cnt++;
      end
   endtask

   task automatic test_clamps();
      int n; bit to;
      mode = 2'd2; wsize = 4'd0; stride = 4'd0;
      pulse_clear();
      send_sym(17);
      model_window(1, 1'b1);
      collect(1'b0, n, to);
      total_cnt++;
      if (to || n != 1 || rec[0] !== exp_e[0]) $display("FAIL w0_single got n=%0d e=%h exp n=1 e=%h", n, rec[0], exp_e[0]);
      else pass_cnt++;
      wsize = 4'd15; stride = 4'd1;
      pulse_clear();
      for (int i = 0; i < 13; i++) begin
         send_sym(int'($urandom_range(0, 63)));
         model_window(12, 1'b1);
         collect(1'b0, n, to);
         total_cnt++;
         if (to || n != 12) $display("FAIL w15_len i=%0d got=%0d exp=12", i, n); else pass_cnt++;
         for (int k = 0; k < 12 && k < n; k++) begin
            total_cnt++;
            if (rec[k] !== exp_e[k]) $display("FAIL w15_elem i=%0d k=%0d got=%h exp=%h", i, k, rec[k], exp_e[k]);
            else pass_cnt++;
         end
      end
   endtask

   task automatic test_pass();
      logic [20:0] exp_p;
      mode = 2'd0; wsize = 4'd3; stride = 4'd1;
      pulse_clear();
      for (int c = 0; c < 12; c++) begin
         if (c == 8) mode = 2'd3;
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         in_value  = (c < 4) ? 6'd9 : 6'($urandom_range(0, 63));
         shift_in  = (c < 4) ? 11'd37 : 11'($urandom_range(0, 2047));
         #1;
         exp_p = {in_valid, out_ready, in_value, shift_in, 1'b0, 1'b1};
         total_cnt++;
         if ({out_valid, in_ready, out_value, out_shift, out_zero, out_last} !== exp_p)
            $display("FAIL pass_mirror c=%0d got=%h exp=%h", c,
                     {out_valid, in_ready, out_value, out_shift, out_zero, out_last}, exp_p);
         else pass_cnt++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
   endtask

   task automatic test_random();
      int n; bit to;
      int w, s, cnt;
      bit sig;
      for (int r = 0; r < 6; r++) begin
         sig    = 1'($urandom_range(0, 1));
         mode   = sig ? 2'd2 : 2'd1;
         wsize  = 4'($urandom_range(0, 15));
         stride = 4'($urandom_range(0, 4));
         w = clamp_w(int'(wsize));
         s = (stride == 0) ? 1 : int'(stride);
         pulse_clear();
         cnt = 0;
         for (int i = 0; i < 3 * s + 2; i++) begin
            send_sym(int'($urandom_range(0, 63)));
            cnt++;
            #1;
            if (cnt % s != 0) begin
               total_cnt++;
               if ({out_valid, in_ready} !== 2'b01) $display("FAIL rnd_no_emit r=%0d i=%0d got v/r=%b exp=01", r, i, {out_valid, in_ready});
               else pass_cnt++;
            end else begin
               model_window(w, sig);
               collect(1'b1, n, to);
               total_cnt++;
               if (to || n != exp_n) $display("FAIL rnd_len r=%0d i=%0d got=%0d exp=%0d", r, i, n, exp_n); else pass_cnt++;
               for (int k = 0; k < exp_n && k < n; k++) begin
                  total_cnt++;
                  if (rec[k] !== exp_e[k]) $display("FAIL rnd_elem r=%0d i=%0d k=%0d got=%h exp=%h", r, i, k, rec[k], exp_e[k]);
                  else pass_cnt++;
               end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_signature();
      test_ngram_stride();
      test_backpressure();
      test_clear_abort();
      test_config_latch();
      test_clamps();
      test_pass();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached passed=%0d total=%0d", pass_cnt, total_cnt);
      $fatal(1, "watchdog");
   end

endmodule
